// File: rtl/clk_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_pkg
// Shared definitions for the clock divider ratio controller:
//   state_e        - controller FSM states
//   MIN_RATIO      - smallest divide ratio the divider can run with
//   is_legal_ratio - true when a requested ratio can be applied
// -----------------------------------------------------------------------------
package clk_div_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GATE,
      LOAD,
      SETTLE,
      ACK
   } state_e;

   localparam logic [31:0] MIN_RATIO = 32'd2;

   // Ratios 0 and 1 cannot be produced by an integer divider and are rejected.
   function automatic logic is_legal_ratio(input logic [31:0] ratio);
      return (ratio >= MIN_RATIO);
   endfunction

endpackage

// File: rtl/clk_div_ctrl_rr_arb.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_rr_arb
// Round-robin arbiter for ratio-change requests. The search for a winner starts
// at the pointer; the pointer moves past the served requester only when that
// requester is acknowledged.
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-high reset (pointer back to 0)
//   req_i       per-requester request vector
//   adv_i       acknowledge strobe, advances the pointer
//   adv_idx_i   index of the requester being acknowledged
//   gnt_valid_o at least one request is pending
//   gnt_idx_o   index of the winning requester
// -----------------------------------------------------------------------------
module clk_div_ctrl_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               adv_i,
   input  logic [IDX_W-1:0]   adv_idx_i,
   output logic               gnt_valid_o,
   output logic [IDX_W-1:0]   gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q;
   int               cand;

   // Scan requesters starting at the pointer and wrapping; the first active
   // request found wins.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      cand        = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(ptr_q) + i) % NUM_REQ;
         if (!gnt_valid_o && req_i[IDX_W'(cand)]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = IDX_W'(cand);
         end
      end
   end

   // The pointer lands just after the acknowledged requester so it gets the
   // lowest priority in the next round.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (adv_i) begin
         if (adv_idx_i == IDX_W'(NUM_REQ - 1)) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= adv_idx_i + 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Runtime controller for an integer clock divider. Arbitrates ratio-change
// requests and sequences each change glitch-free: gate the divider, drain,
// load the new ratio with a counter clear, re-enable, settle, acknowledge.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   en_i         global divider enable
//   req_valid_i  per-requester change request
//   req_ratio_i  per-requester requested ratio, stable while valid
//   req_ready_o  one-cycle acknowledge to the granted requester
//   req_err_o    qualifies req_ready_o: request rejected
//   div_en_o     divider enable
//   div_ratio_o  ratio applied to the divider
//   div_clr_o    one-cycle divider counter clear
//   busy_o       a change sequence is in progress
// -----------------------------------------------------------------------------
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int RATIO_W       = 8,
   parameter int DEFAULT_RATIO = 4,
   parameter int DRAIN_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            en_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   input  logic [NUM_REQ-1:0][RATIO_W-1:0] req_ratio_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   output logic                            req_err_o,
   output logic                            div_en_o,
   output logic [RATIO_W-1:0]              div_ratio_o,
   output logic                            div_clr_o,
   output logic                            busy_o
);

   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   if (DEFAULT_RATIO < int'(MIN_RATIO)) begin : g_bad_default
      $error("clk_div_ctrl: DEFAULT_RATIO must be at least 2");
   end
   if (DRAIN_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
      $error("clk_div_ctrl: DRAIN_CYCLES and SETTLE_CYCLES must be at least 1");
   end
   if (NUM_REQ < 1) begin : g_bad_num_req
      $error("clk_div_ctrl: NUM_REQ must be at least 1");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   gnt_q, gnt_d;
   logic               err_q, err_d;
   logic [RATIO_W-1:0] new_ratio_q, new_ratio_d;
   logic [RATIO_W-1:0] ratio_q, ratio_d;

   logic               arb_valid;
   logic [IDX_W-1:0]   arb_idx;
   logic [RATIO_W-1:0] sel_ratio;
   logic               gate;

   clk_div_ctrl_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_valid_i),
      .adv_i       (state_q == ACK),
      .adv_idx_i   (gnt_q),
      .gnt_valid_o (arb_valid),
      .gnt_idx_o   (arb_idx)
   );

   assign sel_ratio = req_ratio_i[arb_idx];

   // Next-state logic. The grant decision in IDLE looks at the winner's ratio
   // directly so an illegal or unchanged ratio is acknowledged one cycle later
   // without ever gating the divider.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      err_d       = err_q;
      new_ratio_d = new_ratio_q;
      ratio_d     = ratio_q;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt_d       = arb_idx;
               new_ratio_d = sel_ratio;
               if (!is_legal_ratio(32'(sel_ratio))) begin
                  err_d   = 1'b1;
                  state_d = ACK;
               end else if (sel_ratio == ratio_q) begin
                  err_d   = 1'b0;
                  state_d = ACK;
               end else begin
                  err_d   = 1'b0;
                  cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                  state_d = GATE;
               end
            end
         end
         GATE: begin
            if (cnt_q == '0) begin
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         LOAD: begin
            ratio_d = new_ratio_q;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and captured-request registers. Reset mid-sequence drops
   // the pending change entirely; the requester has to ask again.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         gnt_q       <= '0;
         err_q       <= 1'b0;
         new_ratio_q <= '0;
         ratio_q     <= RATIO_W'(DEFAULT_RATIO);
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         err_q       <= err_d;
         new_ratio_q <= new_ratio_d;
         ratio_q     <= ratio_d;
      end
   end

   // Outputs decoded from the registered state, so they are glitch-free
   // relative to the clock. The divider is gated only while it drains and
   // while the new ratio is loaded.
   always_comb begin
      req_ready_o = '0;
      if (state_q == ACK) begin
         req_ready_o[gnt_q] = 1'b1;
      end
   end

   assign gate        = (state_q == GATE) || (state_q == LOAD);
   assign div_en_o    = en_i & ~gate;
   assign div_clr_o   = (state_q == LOAD);
   assign div_ratio_o = ratio_q;
   assign req_err_o   = (state_q == ACK) & err_q;
   assign busy_o      = (state_q != IDLE);

   // A requester must keep valid asserted until it sees ready.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_proto
      a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
         (req_valid_i[g] && !req_ready_o[g]) |=> req_valid_i[g]);
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed bench for clk_div_ctrl. Each request pushes its expected
// acknowledge (requester, error flag, resulting ratio, cycle) into a
// scoreboard; a monitor pops and compares whenever an acknowledge appears.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

   localparam int NUM_REQ = 4;
   localparam int RATIO_W = 8;

   logic                            clk_i = 1'b0;
   logic                            rst_i;
   logic                            en_i;
   logic [NUM_REQ-1:0]              req_valid_i;
   logic [NUM_REQ-1:0][RATIO_W-1:0] req_ratio_i;
   logic [NUM_REQ-1:0]              req_ready_o;
   logic                            req_err_o;
   logic                            div_en_o;
   logic [RATIO_W-1:0]              div_ratio_o;
   logic                            div_clr_o;
   logic                            busy_o;

   typedef struct {
      int idx;
      bit err;
      int ratio;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   clk_div_ctrl #(
      .NUM_REQ       (NUM_REQ),
      .RATIO_W       (RATIO_W),
      .DEFAULT_RATIO (4),
      .DRAIN_CYCLES  (2),
      .SETTLE_CYCLES (1)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .req_valid_i (req_valid_i),
      .req_ratio_i (req_ratio_i),
      .req_ready_o (req_ready_o),
      .req_err_o   (req_err_o),
      .div_en_o    (div_en_o),
      .div_ratio_o (div_ratio_o),
      .div_clr_o   (div_clr_o),
      .busy_o      (busy_o)
   );

   // Free-running clock and a cycle counter used to time acknowledges.
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Raise a request; when an acknowledge is expected, record what it must
   // look like and the cycle it must arrive in (lat cycles after this one).
   task automatic applyStimulus(input int idx, input int ratio, input bit err,
                                input int newRatio, input int lat, input bit expectAck);
      exp_t e;
      req_ratio_i[idx] = RATIO_W'(ratio);
      req_valid_i[idx] = 1'b1;
      if (expectAck) begin
         e.idx   = idx;
         e.err   = err;
         e.ratio = newRatio;
         e.cyc   = cyc + lat;
         sb.push_back(e);
      end
   endtask

   // Wait until all expected acks arrived and the DUT is idle, bounded.
   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while ((busy_o || sb.size() != 0 || req_valid_i != '0) && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      vectors++;
      if (n >= budget) begin
         miscompares++;
         $display("[TB] FAIL idle_timeout: got %0d pending acks, expected 0", sb.size());
         sb.delete();
         req_valid_i = '0;
      end
      @(negedge clk_i);
   endtask

   // Monitor: every acknowledge is matched against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (req_ready_o != '0) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_ack: got ready=%b, expected none", req_ready_o);
            end else begin
               e = sb.pop_front();
               checkOutput("ack_grant", 32'(req_ready_o), 32'(1) << e.idx);
               checkOutput("ack_err", 32'(req_err_o), 32'(e.err));
               checkOutput("ack_ratio", 32'(div_ratio_o), e.ratio);
               checkOutput("ack_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // Requester model: drop valid just after the edge that completes the
   // valid & ready transfer.
   initial begin
      forever begin
         logic [NUM_REQ-1:0] r;
         @(negedge clk_i);
         r = req_ready_o;
         if (r != '0) begin
            @(posedge clk_i);
            #1;
            req_valid_i = req_valid_i & ~r;
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      miscompares++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      rst_i       = 1'b1;
      en_i        = 1'b1;
      req_valid_i = '0;
      req_ratio_i = '0;
      repeat (2) @(negedge clk_i);

      // Reset state
      checkOutput("rst_ratio", 32'(div_ratio_o), 4);
      checkOutput("rst_en", 32'(div_en_o), 1);
      checkOutput("rst_busy", 32'(busy_o), 0);
      checkOutput("rst_ready", 32'(req_ready_o), 0);
      checkOutput("rst_err", 32'(req_err_o), 0);
      checkOutput("rst_clr", 32'(div_clr_o), 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Reset in the middle of GATE aborts the change with no ack
      applyStimulus(0, 8, 1'b0, 0, 0, 1'b0);
      @(negedge clk_i);
      checkOutput("gate_busy", 32'(busy_o), 1);
      checkOutput("gate_en", 32'(div_en_o), 0);
      rst_i       = 1'b1;
      req_valid_i = '0;
      #1;
      checkOutput("abort_busy", 32'(busy_o), 0);
      checkOutput("abort_ratio", 32'(div_ratio_o), 4);
      checkOutput("abort_en", 32'(div_en_o), 1);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checkOutput("abort_noack_busy", 32'(busy_o), 0);

      // Req0 ratio 8: gated cycles 1-3, clear in 3, new ratio from 4, ack in 5
      applyStimulus(0, 8, 1'b0, 8, 5, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_i);
         checkOutput($sformatf("chg_en_c%0d", k), 32'(div_en_o), (k <= 3) ? 1'b0 : 1'b1);
         checkOutput($sformatf("chg_clr_c%0d", k), 32'(div_clr_o), (k == 3) ? 1'b1 : 1'b0);
         checkOutput($sformatf("chg_ratio_c%0d", k), 32'(div_ratio_o), (k >= 4) ? 8 : 4);
      end
      waitIdle(20);

      // Req1 same ratio: ack in cycle 1, divider untouched
      applyStimulus(1, 8, 1'b0, 8, 1, 1'b1);
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk_i);
         checkOutput($sformatf("same_en_c%0d", k), 32'(div_en_o), 1);
         checkOutput($sformatf("same_clr_c%0d", k), 32'(div_clr_o), 0);
      end
      waitIdle(20);

      // Req2 illegal ratios 1 and 0: error ack in cycle 1
      applyStimulus(2, 1, 1'b1, 8, 1, 1'b1);
      @(negedge clk_i);
      checkOutput("err1_en", 32'(div_en_o), 1);
      checkOutput("err1_clr", 32'(div_clr_o), 0);
      waitIdle(20);
      applyStimulus(2, 0, 1'b1, 8, 1, 1'b1);
      @(negedge clk_i);
      checkOutput("err0_ratio", 32'(div_ratio_o), 8);
      waitIdle(20);

      // Req3 same ratio, which also moves the pointer back to 0
      applyStimulus(3, 8, 1'b0, 8, 1, 1'b1);
      waitIdle(20);

      // All four at once: served 0,1,2,3, six cycles apart
      applyStimulus(0, 3, 1'b0, 3, 5, 1'b1);
      applyStimulus(1, 5, 1'b0, 5, 11, 1'b1);
      applyStimulus(2, 6, 1'b0, 6, 17, 1'b1);
      applyStimulus(3, 7, 1'b0, 7, 23, 1'b1);
      waitIdle(60);

      // Only 1 and 3: grant 1 then 3
      applyStimulus(1, 9, 1'b0, 9, 5, 1'b1);
      applyStimulus(3, 10, 1'b0, 10, 11, 1'b1);
      waitIdle(40);

      // en_i low: divider stays disabled, sequence still completes
      en_i = 1'b0;
      applyStimulus(0, 12, 1'b0, 12, 5, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_i);
         checkOutput($sformatf("dis_en_c%0d", k), 32'(div_en_o), 0);
      end
      checkOutput("dis_ratio", 32'(div_ratio_o), 12);
      waitIdle(20);
      en_i = 1'b1;
      #1;
      checkOutput("reen_en", 32'(div_en_o), 1);

      // Boundary ratios: minimum legal 2 and all-ones 255
      applyStimulus(1, 2, 1'b0, 2, 5, 1'b1);
      waitIdle(20);
      applyStimulus(2, 255, 1'b0, 255, 5, 1'b1);
      waitIdle(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
